// File: rtl/ysyx_24100006_wb_pkg.sv
//==============================================================================
// Module  : ysyx_24100006_wb_pkg
// Brief   : Shared types for the writeback/retire stage: retire-queue entry,
//           RUN/HALT state encoding and trap-cause width.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

package ysyx_24100006_wb_pkg;

  localparam int IRQ_NO_W   = 4;

  // Entry fields are sized for the widest configuration supported; the top
  // level zero-extends narrower parameters on push and slices them on pop.
  localparam int XLEN_MAX   = 64;
  localparam int GPR_AW_MAX = 5;
  localparam int CSR_AW_MAX = 12;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                  gpr_we;
    logic [GPR_AW_MAX-1:0] gpr_addr;
    logic [XLEN_MAX-1:0]   gpr_wdata;
    logic                  csr_we;
    logic [CSR_AW_MAX-1:0] csr_addr;
    logic [XLEN_MAX-1:0]   csr_wdata;
    logic                  irq;
    logic [IRQ_NO_W-1:0]   irq_no;
    logic                  brk;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_24100006_wb_fifo.sv
//==============================================================================
// Module  : ysyx_24100006_wb_fifo
// Brief   : In-order retire queue. Pointers carry one extra bit so full and
//           empty are distinguishable; all slots are exported oldest-first
//           together with per-slot valid bits for the bypass search.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module ysyx_24100006_wb_fifo
  import ysyx_24100006_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  wb_entry_t        i_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic             o_empty,
  output wb_entry_t        o_head,
  output wb_entry_t        o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] w_count;

  assign w_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  // Pointer update; a flush drops everything, including a same-cycle push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full) r_wptr <= r_wptr + PW'(1);
      if (i_pop && !o_empty) r_rptr <= r_rptr + PW'(1);
    end
  end

  // Entry storage; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (i_push && !o_full && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_entry;
  end

  // Age-ordered view: slot 0 is the head, higher slots are younger.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_view
      logic [AW-1:0] w_idx;
      assign w_idx        = r_rptr[AW-1:0] + AW'(k);
      assign o_entries[k] = r_mem[w_idx];
      assign o_valid[k]   = (PW'(k) < w_count);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ysyx_24100006_wb_retire.sv
//==============================================================================
// Module  : ysyx_24100006_wb_retire
// Brief   : Writeback/retire stage. Buffers MEM/WB results in an in-order
//           queue, drains one entry per cycle into the GPR/CSR write ports,
//           counts retired instructions and halts on a retired ebreak.
//           Define WB_RETIRE_BYPASS_EN to build the queued-GPR bypass to
//           decode; otherwise the bypass outputs are tied to zero.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module ysyx_24100006_wb_retire
  import ysyx_24100006_wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 4,
  parameter int CSR_AW = 12,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_gpr_we,
  input  logic [GPR_AW-1:0]   in_gpr_addr,
  input  logic [XLEN-1:0]     in_gpr_wdata,
  input  logic                in_csr_we,
  input  logic [CSR_AW-1:0]   in_csr_addr,
  input  logic [XLEN-1:0]     in_csr_wdata,
  input  logic                in_irq,
  input  logic [IRQ_NO_W-1:0] in_irq_no,
  input  logic                in_break,
  input  logic                hold,
  output logic                gpr_we,
  output logic [GPR_AW-1:0]   gpr_addr,
  output logic [XLEN-1:0]     gpr_wdata,
  output logic                csr_we,
  output logic [CSR_AW-1:0]   csr_addr,
  output logic [XLEN-1:0]     csr_wdata,
  output logic                irq,
  output logic [IRQ_NO_W-1:0] irq_no,
  output logic                halt,
  output logic [CNT_W-1:0]    instret,
  input  logic [GPR_AW-1:0]   rs1_addr,
  input  logic [GPR_AW-1:0]   rs2_addr,
  output logic                rs1_hit,
  output logic [XLEN-1:0]     rs1_data,
  output logic                rs2_hit,
  output logic [XLEN-1:0]     rs2_data
);

  wb_state_e        r_state;
  wb_state_e        w_state_nxt;
  wb_entry_t        w_in_entry;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_flush;
  logic             w_push;
  logic [CNT_W-1:0] r_instret;
  logic             w_unused_bits;

  // Pack the incoming beat into the package-wide entry layout.
  always_comb begin
    w_in_entry           = '0;
    w_in_entry.gpr_we    = in_gpr_we;
    w_in_entry.gpr_addr  = GPR_AW_MAX'(in_gpr_addr);
    w_in_entry.gpr_wdata = XLEN_MAX'(in_gpr_wdata);
    w_in_entry.csr_we    = in_csr_we;
    w_in_entry.csr_addr  = CSR_AW_MAX'(in_csr_addr);
    w_in_entry.csr_wdata = XLEN_MAX'(in_csr_wdata);
    w_in_entry.irq       = in_irq;
    w_in_entry.irq_no    = in_irq_no;
    w_in_entry.brk       = in_break;
  end

  assign w_push = in_valid && in_ready;

  ysyx_24100006_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_entry   (w_in_entry),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  // RUN/HALT state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state, handshake and write-strobe gating; ready is held low while
  // reset is asserted so upstream never sees a spurious accept.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    in_ready    = 1'b0;
    gpr_we      = 1'b0;
    csr_we      = 1'b0;
    irq         = 1'b0;
    halt        = 1'b0;
    case (r_state)
      ST_RUN: begin
        in_ready = reset && !w_full;
        w_pop    = !w_empty && !hold;
        if (w_pop) begin
          gpr_we = w_head.gpr_we && (w_head.gpr_addr != '0) && !w_head.irq;
          csr_we = w_head.csr_we;
          irq    = w_head.irq;
          if (w_head.brk) begin
            w_flush     = 1'b1;
            w_state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: halt = 1'b1;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign gpr_addr  = w_head.gpr_addr[GPR_AW-1:0];
  assign gpr_wdata = w_head.gpr_wdata[XLEN-1:0];
  assign csr_addr  = w_head.csr_addr[CSR_AW-1:0];
  assign csr_wdata = w_head.csr_wdata[XLEN-1:0];
  assign irq_no    = w_head.irq_no;

  // Retired-instruction counter; traps do not count, wraps freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_instret <= '0;
    else if (w_pop && !w_head.irq) r_instret <= r_instret + CNT_W'(1);
  end

  assign instret = r_instret;

`ifdef WB_RETIRE_BYPASS_EN
  // Scan oldest to youngest so the youngest matching write wins.
  always_comb begin
    rs1_hit  = 1'b0;
    rs1_data = '0;
    rs2_hit  = 1'b0;
    rs2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_valid[k] && w_entries[k].gpr_we && !w_entries[k].irq) begin
        if ((rs1_addr != '0) && (w_entries[k].gpr_addr[GPR_AW-1:0] == rs1_addr)) begin
          rs1_hit  = 1'b1;
          rs1_data = w_entries[k].gpr_wdata[XLEN-1:0];
        end
        if ((rs2_addr != '0) && (w_entries[k].gpr_addr[GPR_AW-1:0] == rs2_addr)) begin
          rs2_hit  = 1'b1;
          rs2_data = w_entries[k].gpr_wdata[XLEN-1:0];
        end
      end
    end
  end
`else
  assign rs1_hit  = 1'b0;
  assign rs1_data = '0;
  assign rs2_hit  = 1'b0;
  assign rs2_data = '0;
`endif

  // Fold entry bits not consumed in every build/parameterisation into a sink.
  always_comb begin
    w_unused_bits = ^w_head ^ (^rs1_addr) ^ (^rs2_addr);
    for (int k = 0; k < DEPTH; k++) begin
      w_unused_bits = w_unused_bits ^ (^w_entries[k]) ^ w_valid[k];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100006_wb_retire.sv
`default_nettype none

module tb_ysyx_24100006_wb_retire;

  localparam int XLEN   = 32;
  localparam int GPR_AW = 4;
  localparam int CSR_AW = 12;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_gpr_we = 1'b0;
  logic [GPR_AW-1:0] in_gpr_addr = '0;
  logic [XLEN-1:0]   in_gpr_wdata = '0;
  logic              in_csr_we = 1'b0;
  logic [CSR_AW-1:0] in_csr_addr = '0;
  logic [XLEN-1:0]   in_csr_wdata = '0;
  logic              in_irq = 1'b0;
  logic [3:0]        in_irq_no = '0;
  logic              in_break = 1'b0;
  logic              hold = 1'b0;
  logic              gpr_we;
  logic [GPR_AW-1:0] gpr_addr;
  logic [XLEN-1:0]   gpr_wdata;
  logic              csr_we;
  logic [CSR_AW-1:0] csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic              irq;
  logic [3:0]        irq_no;
  logic              halt;
  logic [CNT_W-1:0]  instret;
  logic [GPR_AW-1:0] rs1_addr = '0;
  logic [GPR_AW-1:0] rs2_addr = '0;
  logic              rs1_hit;
  logic [XLEN-1:0]   rs1_data;
  logic              rs2_hit;
  logic [XLEN-1:0]   rs2_data;

  always #5 clk = ~clk;

  ysyx_24100006_wb_retire #(
    .XLEN(XLEN), .GPR_AW(GPR_AW), .CSR_AW(CSR_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_gpr_we(in_gpr_we), .in_gpr_addr(in_gpr_addr), .in_gpr_wdata(in_gpr_wdata),
    .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
    .in_irq(in_irq), .in_irq_no(in_irq_no), .in_break(in_break), .hold(hold),
    .gpr_we(gpr_we), .gpr_addr(gpr_addr), .gpr_wdata(gpr_wdata),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .irq(irq), .irq_no(irq_no), .halt(halt), .instret(instret),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_hit(rs1_hit), .rs1_data(rs1_data), .rs2_hit(rs2_hit), .rs2_data(rs2_data)
  );

`ifdef WB_RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        gwe;
    logic [3:0]  ga;
    logic [31:0] gd;
    logic        cwe;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        irq;
    logic [3:0]  ino;
    logic        brk;
  } beat_t;

  typedef struct {
    beat_t       b;
    logic        e_gwe;
    logic        e_cwe;
    logic        e_irq;
    logic [63:0] e_inc;
  } vec_t;

  // Scoreboard: queued beats awaiting retirement plus architectural state.
  beat_t       mq[$];
  logic        m_halt = 1'b0;
  logic [63:0] m_instret = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        vt[6];
  beat_t       idle_b;

  function automatic beat_t mk(input logic gwe, input logic [3:0] ga, input logic [31:0] gd,
                               input logic cwe, input logic [11:0] ca, input logic [31:0] cd,
                               input logic iq, input logic [3:0] ino, input logic brk);
    beat_t b;
    b.gwe = gwe; b.ga = ga; b.gd = gd; b.cwe = cwe; b.ca = ca; b.cd = cd;
    b.irq = iq;  b.ino = ino; b.brk = brk;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input beat_t b, input logic v, input logic h);
    in_valid     = v;
    hold         = h;
    in_gpr_we    = b.gwe;
    in_gpr_addr  = b.ga;
    in_gpr_wdata = b.gd;
    in_csr_we    = b.cwe;
    in_csr_addr  = b.ca;
    in_csr_wdata = b.cd;
    in_irq       = b.irq;
    in_irq_no    = b.ino;
    in_break     = b.brk;
  endtask

  task automatic model_bypass(input logic [3:0] rs, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (BYP && rs != 4'd0) begin
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (!hit && mq[k].gwe && !mq[k].irq && mq[k].ga == rs) begin
          hit = 1'b1;
          d   = mq[k].gd;
        end
      end
    end
  endtask

  task automatic check_model();
    logic        e_pop;
    logic        e_gwe;
    logic        bh;
    logic [31:0] bd;
    beat_t       hd;
    e_pop = reset && !m_halt && (mq.size() > 0) && !hold;
    chk("in_ready", in_ready, reset && !m_halt && (mq.size() < DEPTH));
    chk("halt", halt, m_halt);
    chk("instret", instret, m_instret);
    if (e_pop) begin
      hd    = mq[0];
      e_gwe = hd.gwe && (hd.ga != 4'd0) && !hd.irq;
      chk("gpr_we", gpr_we, e_gwe);
      chk("csr_we", csr_we, hd.cwe);
      chk("irq", irq, hd.irq);
      if (e_gwe) begin
        chk("gpr_addr", gpr_addr, hd.ga);
        chk("gpr_wdata", gpr_wdata, hd.gd);
      end
      if (hd.cwe) begin
        chk("csr_addr", csr_addr, hd.ca);
        chk("csr_wdata", csr_wdata, hd.cd);
      end
      if (hd.irq) chk("irq_no", irq_no, hd.ino);
    end else begin
      chk("gpr_we_idle", gpr_we, 1'b0);
      chk("csr_we_idle", csr_we, 1'b0);
      chk("irq_idle", irq, 1'b0);
    end
    model_bypass(rs1_addr, bh, bd);
    chk("rs1_hit", rs1_hit, bh);
    chk("rs1_data", rs1_data, bd);
    model_bypass(rs2_addr, bh, bd);
    chk("rs2_hit", rs2_hit, bh);
    chk("rs2_data", rs2_data, bd);
  endtask

  task automatic model_update();
    logic  rdy;
    logic  pop;
    logic  flush;
    beat_t hd;
    rdy   = !m_halt && (mq.size() < DEPTH);
    pop   = !m_halt && (mq.size() > 0) && !hold;
    flush = 1'b0;
    if (pop) begin
      hd = mq.pop_front();
      if (!hd.irq) m_instret = m_instret + 64'd1;
      if (hd.brk) begin
        m_halt = 1'b1;
        flush  = 1'b1;
        mq.delete();
      end
    end
    if (in_valid && rdy && !flush)
      mq.push_back(mk(in_gpr_we, in_gpr_addr, in_gpr_wdata, in_csr_we, in_csr_addr,
                      in_csr_wdata, in_irq, in_irq_no, in_break));
  endtask

  // One clock: compare at the falling edge, advance the model, resume 1ns
  // after the rising edge.
  task automatic step();
    @(negedge clk);
    check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(idle_b, 1'b0, 1'b0);
    mq.delete();
    m_halt    = 1'b0;
    m_instret = '0;
    #1;
    chk("ready_in_reset", in_ready, 1'b0);
    chk("halt_in_reset", halt, 1'b0);
    chk("instret_in_reset", instret, 64'd0);
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_ir;
    beat_t b;

    idle_b = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[0] = '{b: mk(1, 4'd5,  32'h1234,     0, 12'h0,   32'h0,         0, 0, 0), e_gwe: 1, e_cwe: 0, e_irq: 0, e_inc: 1};
    vt[1] = '{b: mk(1, 4'd0,  32'hFFFF,     0, 12'h0,   32'h0,         0, 0, 0), e_gwe: 0, e_cwe: 0, e_irq: 0, e_inc: 1};
    vt[2] = '{b: mk(0, 4'd0,  32'h0,        1, 12'h300, 32'h8,         0, 0, 0), e_gwe: 0, e_cwe: 1, e_irq: 0, e_inc: 1};
    vt[3] = '{b: mk(1, 4'd1,  32'h77,       1, 12'h341, 32'h80000010,  1, 7, 0), e_gwe: 0, e_cwe: 1, e_irq: 1, e_inc: 0};
    vt[4] = '{b: mk(0, 4'd0,  32'h0,        0, 12'h0,   32'h0,         0, 0, 0), e_gwe: 0, e_cwe: 0, e_irq: 0, e_inc: 1};
    vt[5] = '{b: mk(1, 4'd15, 32'hDEADBEEF, 0, 12'h0,   32'h0,         0, 0, 0), e_gwe: 1, e_cwe: 0, e_irq: 0, e_inc: 1};

    do_reset();

    // Single beats into an empty queue: write visible the cycle after accept.
    exp_ir = 64'd0;
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].b, 1'b1, 1'b0);
      step();
      drive(idle_b, 1'b0, 1'b0);
      chk("tbl_gpr_we", gpr_we, vt[i].e_gwe);
      chk("tbl_csr_we", csr_we, vt[i].e_cwe);
      chk("tbl_irq", irq, vt[i].e_irq);
      if (vt[i].e_gwe) chk("tbl_gpr_wdata", gpr_wdata, vt[i].b.gd);
      if (vt[i].e_irq) chk("tbl_irq_no", irq_no, vt[i].b.ino);
      step();
      exp_ir = exp_ir + vt[i].e_inc;
      chk("tbl_instret", instret, exp_ir);
    end

    // Hold fills the queue; release drains in order with push resuming later.
    drive(mk(1, 4'd6, 32'h111, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    step();
    drive(mk(1, 4'd7, 32'h222, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    step();
    drive(mk(1, 4'd8, 32'h333, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    #1;
    chk("hold_full_ready", in_ready, 1'b0);
    step();
    step();
    drive(mk(1, 4'd8, 32'h333, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    #1;
    chk("hold_order1", gpr_wdata, 32'h111);
    chk("full_pop_ready", in_ready, 1'b0);
    step();
    chk("hold_order2", gpr_wdata, 32'h222);
    step();
    drive(idle_b, 1'b0, 1'b0);
    chk("hold_order3", gpr_wdata, 32'h333);
    step();
    step();

    // Bypass: youngest queued write to x3 wins.
    drive(mk(1, 4'd3, 32'hA, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    step();
    drive(mk(1, 4'd3, 32'hB, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    step();
    drive(idle_b, 1'b0, 1'b1);
    rs1_addr = 4'd3;
    rs2_addr = 4'd5;
    #1;
    chk("byp_rs1_hit", rs1_hit, BYP);
    chk("byp_rs1_data", rs1_data, BYP ? 32'hB : 32'h0);
    chk("byp_rs2_miss", rs2_hit, 1'b0);
    rs1_addr = 4'd0;
    #1;
    chk("byp_rs1_x0", rs1_hit, 1'b0);
    step();
    drive(idle_b, 1'b0, 1'b0);
    step();
    step();
    step();

    // Asynchronous reset mid-operation discards queued entries.
    drive(mk(1, 4'd9, 32'h999, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    step();
    step();
    do_reset();
    drive(idle_b, 1'b0, 1'b0);
    step();
    step();
    chk("post_reset_instret", instret, 64'd0);

    // Randomised traffic with random hold and bypass probes.
    for (int c = 0; c < 300; c++) begin
      b = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), $urandom,
             1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), 1'b0);
      drive(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      rs1_addr = 4'($urandom_range(0, 15));
      rs2_addr = 4'($urandom_range(0, 15));
      step();
    end
    drive(idle_b, 1'b0, 1'b0);
    step();
    step();

    // ebreak retires, the following beat is discarded, core stays halted.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 1'b0);
    step();
    drive(mk(1, 4'd2, 32'h55, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    step();
    chk("brk_halt", halt, 1'b1);
    chk("brk_ready", in_ready, 1'b0);
    chk("brk_no_x2", gpr_we, 1'b0);
    for (int c = 0; c < 4; c++) step();
    do_reset();
    step();
    chk("unhalt", halt, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
